car_ctrl: RTL and testbench
===========================

CAR_CTRL -- requirements
Module: car_ctrl

Interface
REQ-001 SHALL have parameter FLOORS, default 4, number of served floors (floor index 0..3).
REQ-002 SHALL have parameter TRAVEL, default 5'b11001 (25), clk cycles per one-floor move (0.5 s at 50 Hz).
REQ-003 SHALL have parameter DOOR_TO, default 4, cycles allowed for door_open to rise after arrival.
REQ-004 SHALL have port clk, input, 1, 50 Hz system clock; one clock; all state on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port req, input, 4, floor-call pulses, bit n = call to floor n, any length >= 1 cycle.
REQ-007 SHALL have port door_open, input, 1, door-module open signal, 1 while door cycle runs.
REQ-008 SHALL have port arr, output, 1, car stopped at a floor for service (door module arr).
REQ-009 SHALL have port open_en, output, 1, door open permission (door module open_en).
REQ-010 SHALL have port floor, output, 2, current car floor.
REQ-011 SHALL have port dir, output, 1, travel direction, 1 = up, 0 = down.
REQ-012 SHALL have port moving, output, 1, car between floors.
REQ-013 SHALL have port pending, output, 4, latched outstanding calls.

Function
REQ-014 SHALL implement states IDLE, MOVE, ARRIVE, DOOR; outputs registered.
REQ-015 pending[n] SHALL set on the cycle after req[n]=1; set is OR-accumulated, never lost.
REQ-016 IDLE: pending[floor]=1 -> ARRIVE; else pending above and (dir=1 or none below) -> dir=1, MOVE; else pending below -> dir=0, MOVE; else stay IDLE.
REQ-017 MOVE: moving=1, 5-bit cnt counts 0..TRAVEL-1; at TRAVEL-1, floor steps +/-1 per dir, cnt=0.
REQ-018 On each step, pending[new floor]=1 -> ARRIVE, else stay MOVE same direction.
REQ-019 floor SHALL never wrap: stepping past 0 or FLOORS-1 is impossible; reaching an end with no call there is a design error flagged by assertion.
REQ-020 ARRIVE: arr=1, open_en=1, moving=0; door_open=1 -> DOOR; DOOR_TO cycles without door_open -> clear pending[floor], IDLE.
REQ-021 DOOR: arr=1, open_en=0; door_open=0 -> clear pending[floor], arr=0, IDLE.
REQ-022 Calls to the current floor arriving during ARRIVE/DOOR SHALL be absorbed: clear wins over simultaneous set.
REQ-023 Calls to other floors SHALL latch in any state, including MOVE and DOOR.
REQ-024 Total latency IDLE call to other floor: 1 cycle latch + 1 dispatch + TRAVEL per floor + 1 to ARRIVE.

Reset
REQ-025 rst=1 SHALL force immediately: state IDLE, floor=0, dir=1, pending=0, cnt=0, arr=0, open_en=0, moving=0.
REQ-026 rst mid-MOVE or mid-DOOR SHALL abandon the operation; car restarts at floor 0, no calls retained.
REQ-027 After rst release, first state change SHALL occur on the second posedge at earliest.

Structure
REQ-028 Shared package SHALL hold state encoding, FLOORS, TRAVEL, DOOR_TO, floor width.
REQ-029 One sub-module req_reg SHALL hold pending with set/clear and clear-priority; dispatch logic stays in car_ctrl.

Verification
REQ-030 Reset, req=4'b1000 one cycle -> moving=1, floor steps 1,2,3 every 25 cycles, then arr=1, open_en=1 at floor 3.
REQ-031 At floor 3 ARRIVE, door_open high 26 cycles then low -> arr=0, pending=0, state IDLE, floor stays 3.
REQ-032 Car at 0, req=4'b0100 then req=4'b0010 mid-travel -> stops at 1 first (arr=1), then 2.
REQ-033 ARRIVE with door_open held 0 for 4 cycles -> pending[floor] cleared, IDLE, arr=0.
REQ-034 Car at 2 dir=1, pending floors 3 and 0 -> serves 3 first, then dir=0 travels to 0.
REQ-035 rst asserted at cnt=12 in MOVE -> all outputs reset values same cycle, floor=0, pending=0.

Source files
------------

// File: rtl/car_ctrl_pkg.sv
// Shared types and defaults for the single-car elevator controller.
// Widths here fix the bus widths used by car_ctrl_if.
package car_ctrl_pkg;
  localparam int FLOORS = 4;
  localparam int FLOOR_W = 2;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] TRAVEL = 5'b11001;
  localparam logic [CNT_W-1:0] DOOR_TO = 5'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    DOOR   = 2'd3
  } state_t;
endpackage

// File: rtl/car_ctrl_if.sv
// Signal bundle between the car controller and its environment (call buttons, door module).
interface car_ctrl_if;
  import car_ctrl_pkg::*;

  // Door handshake: arr/open_en offer service at floor; the door module answers with
  // door_open high for its whole cycle. The car leaves only after door_open falls, or
  // after DOOR_TO cycles if door_open never rises.
  logic [FLOORS-1:0]  req;
  logic               door_open;
  logic               arr;
  logic               open_en;
  logic [FLOOR_W-1:0] floor;
  logic               dir;
  logic               moving;
  logic [FLOORS-1:0]  pending;

  modport master (
    output req, door_open,
    input  arr, open_en, floor, dir, moving, pending
  );

  modport slave (
    input  req, door_open,
    output arr, open_en, floor, dir, moving, pending
  );
endinterface

// File: rtl/car_ctrl_req_reg.sv
// Latched floor calls: OR-accumulating set, clear takes priority on the same bit.
module car_ctrl_req_reg
  import car_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] set,
  input  logic [FLOORS-1:0] clr,
  output logic [FLOORS-1:0] pending
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending | set) & ~clr;
    end
  end

endmodule

// File: rtl/car_ctrl.sv
// Car dispatcher: IDLE/MOVE/ARRIVE/DOOR controller with registered outputs.
// Keeps direction while calls remain ahead; reverses only when none do.
module car_ctrl #(
  parameter int         FLOORS  = car_ctrl_pkg::FLOORS,
  parameter logic [4:0] TRAVEL  = car_ctrl_pkg::TRAVEL,
  parameter logic [4:0] DOOR_TO = car_ctrl_pkg::DOOR_TO
) (
  input  logic                  clk,
  input  logic                  rst,
  car_ctrl_if.slave             bus,
  output car_ctrl_pkg::state_t  dbg_state
);
  import car_ctrl_pkg::*;

  state_t             state, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, step;
  logic               dir_q, dir_d;
  logic [4:0]         cnt, cnt_d;
  logic [FLOORS-1:0]  pending, clr;
  logic               above, below, here;
  logic               arr_q, open_en_q, moving_q;
  logic               arr_d, open_en_d, moving_d;

  car_ctrl_req_reg req_reg (
    .clk     (clk),
    .rst     (rst),
    .set     (bus.req),
    .clr     (clr),
    .pending (pending)
  );

  // Call position relative to the car, and the floor reached by the next step.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && (i > int'(floor_q))) above = 1'b1;
      if (pending[i] && (i < int'(floor_q))) below = 1'b1;
    end
    here = pending[floor_q];
    if (dir_q) begin
      step = (int'(floor_q) == FLOORS - 1) ? floor_q : floor_q + 1'b1;
    end else begin
      step = (floor_q == '0) ? floor_q : floor_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      cnt       <= '0;
      arr_q     <= 1'b0;
      open_en_q <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      state     <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      cnt       <= cnt_d;
      arr_q     <= arr_d;
      open_en_q <= open_en_d;
      moving_q  <= moving_d;
    end
  end

  always_comb begin
    state_d = state;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt;
    clr     = '0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (here) begin
          state_d = ARRIVE;
        end else if (above && (dir_q || !below)) begin
          dir_d   = 1'b1;
          state_d = MOVE;
        end else if (below) begin
          dir_d   = 1'b0;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (cnt == TRAVEL - 5'd1) begin
          cnt_d   = '0;
          floor_d = step;
          if (pending[step]) state_d = ARRIVE;
        end else begin
          cnt_d = cnt + 5'd1;
        end
      end
      // cnt doubles as the door-response timer while waiting here.
      ARRIVE: begin
        if (bus.door_open) begin
          cnt_d   = '0;
          state_d = DOOR;
        end else if (cnt == DOOR_TO - 5'd1) begin
          cnt_d          = '0;
          clr[floor_q]   = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt + 5'd1;
        end
      end
      DOOR: begin
        if (!bus.door_open) begin
          clr[floor_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arr_d     = (state_d == ARRIVE) || (state_d == DOOR);
    open_en_d = (state_d == ARRIVE);
    moving_d  = (state_d == MOVE);
  end

  assign bus.arr     = arr_q;
  assign bus.open_en = open_en_q;
  assign bus.moving  = moving_q;
  assign bus.floor   = floor_q;
  assign bus.dir     = dir_q;
  assign bus.pending = pending;
  assign dbg_state   = state;

  // The car only travels toward a latched call, so an end floor is never reached empty.
  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    (state == MOVE && cnt == TRAVEL - 5'd1 &&
     ((dir_q && int'(floor_q) == FLOORS - 1) || (!dir_q && floor_q == '0))) |-> 1'b0);
  a_end_has_call: assert property (@(posedge clk) disable iff (rst)
    (state == MOVE && cnt == TRAVEL - 5'd1 &&
     (int'(step) == FLOORS - 1 || step == '0)) |-> pending[step]);

endmodule

// File: tb/tb_car_ctrl.sv
// Bench for car_ctrl: trip table plus hand sequences; arrivals checked against a queue.
module tb_car_ctrl;
  import car_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  car_ctrl_if bus();

  car_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] exp_floor;
    logic       exp_dir;
    int         door_cycles;
  } trip_t;

  trip_t      trips[5];
  logic [1:0] exp_q[$];
  logic [3:0] exp_pend = '0;
  int         total = 0;
  int         bad = 0;
  logic       arr_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arrival monitor: every rising arr must match the next expected floor.
  always @(negedge clk) begin
    if (!rst && bus.arr && !arr_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_arrival: got floor %0d expected no arrival", bus.floor);
      end else begin
        chk("arr_floor", 32'(bus.floor), 32'(exp_q.pop_front()));
        chk("arr_open_en", 32'(bus.open_en), 32'd1);
        chk("arr_moving", 32'(bus.moving), 32'd0);
      end
    end
    arr_prev <= bus.arr;
  end

  task automatic drive_req(input logic [3:0] m);
    bus.req  = m;
    exp_pend = exp_pend | m;
    @(negedge clk);
    bus.req  = '0;
  endtask

  task automatic wait_arr(input string name);
    int n = 0;
    while (!bus.arr && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.arr) begin
      total++;
      bad++;
      $display("FAIL %s: arr stayed 0 for 300 cycles, expected 1", name);
    end
  endtask

  task automatic wait_floor(input string name, input logic [1:0] f, input int exp_cycles);
    int n = 0;
    while (bus.floor != f && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  task automatic serve_door(input int n, input logic [1:0] f);
    if (n == 0) begin
      repeat (3) @(negedge clk);
      chk("timeout_arr_hold", 32'(bus.arr), 32'd1);
      @(negedge clk);
      chk("timeout_arr_drop", 32'(bus.arr), 32'd0);
    end else begin
      bus.door_open = 1'b1;
      @(negedge clk);
      chk("door_open_en", 32'(bus.open_en), 32'd0);
      chk("door_arr", 32'(bus.arr), 32'd1);
      chk("door_state", 32'(dbg_state), 32'(DOOR));
      repeat (n - 1) @(negedge clk);
      bus.door_open = 1'b0;
      @(negedge clk);
      chk("door_arr_drop", 32'(bus.arr), 32'd0);
    end
    exp_pend[f] = 1'b0;
    chk("served_state", 32'(dbg_state), 32'(IDLE));
    chk("served_pending", 32'(bus.pending), 32'(exp_pend));
    chk("served_floor", 32'(bus.floor), 32'(f));
  endtask

  initial begin
    trips[0] = '{4'b0001, 2'd0, 1'b0, 0};
    trips[1] = '{4'b0100, 2'd2, 1'b1, 3};
    trips[2] = '{4'b0100, 2'd2, 1'b1, 0};
    trips[3] = '{4'b0010, 2'd1, 1'b0, 2};
    trips[4] = '{4'b1000, 2'd3, 1'b1, 5};

    rst           = 1'b1;
    bus.req       = '0;
    bus.door_open = 1'b0;
    #1;
    chk("rst_floor", 32'(bus.floor), 32'd0);
    chk("rst_dir", 32'(bus.dir), 32'd1);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_arr", 32'(bus.arr), 32'd0);
    chk("rst_open_en", 32'(bus.open_en), 32'd0);
    chk("rst_moving", 32'(bus.moving), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Call to floor 3 from reset: latch, dispatch, three 25-cycle steps.
    drive_req(4'b1000);
    exp_q.push_back(2'd3);
    chk("latch_pending", 32'(bus.pending), 32'b1000);
    chk("latch_state", 32'(dbg_state), 32'(IDLE));
    chk("latch_moving", 32'(bus.moving), 32'd0);
    @(negedge clk);
    chk("dispatch_moving", 32'(bus.moving), 32'd1);
    chk("dispatch_dir", 32'(bus.dir), 32'd1);
    wait_floor("step_to_1", 2'd1, 25);
    wait_floor("step_to_2", 2'd2, 25);
    wait_floor("step_to_3", 2'd3, 25);
    chk("top_arr", 32'(bus.arr), 32'd1);
    chk("top_open_en", 32'(bus.open_en), 32'd1);
    serve_door(26, 2'd3);

    for (int i = 0; i < 5; i++) begin
      drive_req(trips[i].req);
      exp_q.push_back(trips[i].exp_floor);
      wait_arr("trip_arrive");
      chk("trip_dir", 32'(bus.dir), 32'(trips[i].exp_dir));
      serve_door(trips[i].door_cycles, trips[i].exp_floor);
    end

    // Reset in the middle of a move: everything drops immediately.
    drive_req(4'b0001);
    exp_q.push_back(2'd0);
    begin
      int n = 0;
      while (!bus.moving && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("mid_move_started", 32'(bus.moving), 32'd1);
    end
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_floor", 32'(bus.floor), 32'd0);
    chk("midrst_pending", 32'(bus.pending), 32'd0);
    chk("midrst_moving", 32'(bus.moving), 32'd0);
    chk("midrst_dir", 32'(bus.dir), 32'd1);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    exp_pend = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("post_rst_pending", 32'(bus.pending), 32'd0);

    // A nearer call added during travel is served first.
    drive_req(4'b0100);
    repeat (10) @(negedge clk);
    drive_req(4'b0010);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    wait_arr("near_first");
    serve_door(2, 2'd1);
    wait_arr("far_second");
    chk("far_dir", 32'(bus.dir), 32'd1);
    serve_door(2, 2'd2);

    // At floor 2 heading up with calls at 3 and 0: finish upward, then reverse.
    drive_req(4'b1001);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    wait_arr("sweep_up");
    chk("sweep_up_dir", 32'(bus.dir), 32'd1);
    serve_door(1, 2'd3);
    wait_arr("sweep_down");
    chk("sweep_down_dir", 32'(bus.dir), 32'd0);
    serve_door(3, 2'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
